// File: rtl/pat_seq_pkg.sv
// Shared types and constants for the pattern frame sequencer.
// Holds the phase enum, default widths and the fill-mask constants.
package pat_seq_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_STRM_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONES  = 3'd1,
    SUBC  = 3'd2,
    ZEROS = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DEF_DATA_W-1:0] ALL_ONES  = '1;
  localparam logic [DEF_DATA_W-1:0] ALL_ZEROS = '0;

endpackage

// File: rtl/pat_seq_wr_stage.sv
// Registered write stage into the imager pattern FIFO; selects fill or source data by phase.
// Latency: out_wr/out_data appear one cycle after wr_en.
// Backpressure: none here; the caller only asserts wr_en when the FIFO has headroom.
module pat_seq_wr_stage
  import pat_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  state_t            phase,
  input  logic [DATA_W-1:0] src_data,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] wr_dat;

  // Fill constants are replicated from a single bit so any DATA_W works.
  always_comb begin
    wr_dat = src_data;
    case (phase)
      ONES:    wr_dat = {DATA_W{ALL_ONES[0]}};
      ZEROS:   wr_dat = {DATA_W{ALL_ZEROS[0]}};
      default: wr_dat = src_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr   <= 1'b0;
      out_data <= '0;
    end else begin
      out_wr <= wr_en;
      if (wr_en) out_data <= wr_dat;
    end
  end

endmodule

// File: rtl/pattern_frame_sequencer.sv
// Frame sequencer: optional all-ones mask, num_pat source masks, optional all-zeros mask.
// Latency: each write lands one cycle after its pop/decision cycle.
// Backpressure: stalls on out_full (needs 2 free entries) and on !src_valid.
module pattern_frame_sequencer
  import pat_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STRM_W = DEF_STRM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic              en_reset_masks,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [STRM_W-1:0] num_streams,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_rd_en,
  input  logic              out_full,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              subc_done,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              cfg_err
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  np_r, subc_cnt;
  logic [STRM_W-1:0] ns_r, word_cnt;
  logic              er_r;
  logic              cfg_bad, start_ok, fill_go, wr_en, last_word, last_subc;

  assign cfg_bad   = (num_pat == '0) || (num_streams == '0);
  assign last_word = (word_cnt == ns_r - STRM_W'(1));
  assign last_subc = (subc_cnt == np_r - CNT_W'(1));
  assign wr_en     = fill_go | src_rd_en;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = en_reset_masks ? ONES : SUBC;
        ONES:    if (fill_go && last_word) state_nxt = SUBC;
        SUBC:    if (src_rd_en && last_word && last_subc) state_nxt = er_r ? ZEROS : DONE;
        ZEROS:   if (fill_go && last_word) state_nxt = DONE;
        DONE:    state_nxt = continuous ? (er_r ? ONES : SUBC) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // abort masks every strobe in its own cycle, including the pop.
  always_comb begin
    src_rd_en  = 1'b0;
    fill_go    = 1'b0;
    start_ok   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    if (!abort) begin
      case (state)
        IDLE:        start_ok   = start && !cfg_bad;
        ONES, ZEROS: fill_go    = !out_full;
        SUBC:        src_rd_en  = src_valid && !out_full;
        DONE:        frame_done = 1'b1;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      np_r      <= '0;
      ns_r      <= '0;
      er_r      <= 1'b0;
      word_cnt  <= '0;
      subc_cnt  <= '0;
      frame_cnt <= '0;
      subc_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      subc_done <= src_rd_en && last_word;
      cfg_err   <= !abort && (state == IDLE) && start && cfg_bad;
      if (!abort && (state == IDLE) && start) begin
        np_r     <= num_pat;
        ns_r     <= num_streams;
        er_r     <= en_reset_masks;
        word_cnt <= '0;
        subc_cnt <= '0;
      end
      if (wr_en) word_cnt <= last_word ? '0 : word_cnt + STRM_W'(1);
      if (src_rd_en && last_word) subc_cnt <= last_subc ? '0 : subc_cnt + CNT_W'(1);
      // DONE re-arms the counters so a continuous frame restarts cleanly.
      if (frame_done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        word_cnt  <= '0;
        subc_cnt  <= '0;
      end
    end
  end

  pat_seq_wr_stage #(.DATA_W(DATA_W)) u_wr_stage (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .phase    (state),
    .src_data (src_data),
    .out_wr   (out_wr),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_pattern_frame_sequencer.sv
// Directed bench for pattern_frame_sequencer: a source FIFO model feeds the DUT,
// a negedge monitor logs writes and pulses, and each test task checks its own results.
module tb_pattern_frame_sequencer;

  localparam int DATA_W = 256;
  localparam int CNT_W  = 32;
  localparam int STRM_W = 16;

  logic              clk = 1'b0;
  logic              rst, start, abort, continuous, en_reset_masks;
  logic [CNT_W-1:0]  num_pat;
  logic [STRM_W-1:0] num_streams;
  logic [DATA_W-1:0] src_data;
  logic              src_valid, src_rd_en, out_full, out_wr;
  logic [DATA_W-1:0] out_data;
  logic              busy, subc_done, frame_done, cfg_err;
  logic [CNT_W-1:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int src_idx = 0;
  int cfg_cnt = 0;
  int full_viol = 0;
  int exp_frames = 0;
  logic full_q = 1'b0;
  logic [DATA_W-1:0] wr_log[$];
  int wr_cyc[$];
  int sd_cyc[$];
  int fd_cyc[$];

  localparam logic [DATA_W-1:0] ONES_W  = '1;
  localparam logic [DATA_W-1:0] ZEROS_W = '0;

  function automatic logic [DATA_W-1:0] mk_word(input int i);
    logic [31:0] t;
    t = 32'h5A00_0000 + 32'(i);
    return {8{t}};
  endfunction

  assign src_data = mk_word(src_idx);

  pattern_frame_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STRM_W(STRM_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .continuous     (continuous),
    .en_reset_masks (en_reset_masks),
    .num_pat        (num_pat),
    .num_streams    (num_streams),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_rd_en      (src_rd_en),
    .out_full       (out_full),
    .out_wr         (out_wr),
    .out_data       (out_data),
    .busy           (busy),
    .subc_done      (subc_done),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  // Source FIFO model: head advances on each accepted pop.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_q <= out_full;
    if (src_rd_en) src_idx <= src_idx + 1;
  end

  always @(negedge clk) begin
    if (out_wr) begin
      wr_log.push_back(out_data);
      wr_cyc.push_back(cyc);
    end
    if (subc_done)  sd_cyc.push_back(cyc);
    if (frame_done) fd_cyc.push_back(cyc);
    if (cfg_err)    cfg_cnt++;
    if (out_wr && full_q) full_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; en_reset_masks = 1'b0;
    num_pat = '0; num_streams = '0; src_valid = 1'b0; out_full = 1'b0;
    tick(); tick();
    tests++;
    if ({out_wr, busy, subc_done, frame_done, cfg_err, src_rd_en} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 000000",
               {out_wr, busy, subc_done, frame_done, cfg_err, src_rd_en});
    end
    tests++;
    if (out_data !== ZEROS_W) begin
      fails++;
      $display("FAIL reset_out_data: got %0h, required 0", out_data);
    end
    tests++;
    if (frame_cnt !== '0) begin
      fails++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
    rst = 1'b0;
    src_valid = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || out_wr !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%0b out_wr=%0b, required 0 0", busy, out_wr);
    end
  endtask

  task automatic test_basic();
    int wb, sb, fb, s0, st, errs;
    logic ok;
    logic [DATA_W-1:0] exp;
    wb = wr_log.size(); sb = sd_cyc.size(); fb = fd_cyc.size(); s0 = src_idx;
    en_reset_masks = 1'b1; num_pat = 32'd3; num_streams = 16'd4; continuous = 1'b0;
    src_valid = 1'b1; out_full = 1'b0;
    pulse_start();
    st = cyc;
    wait_idle(100, "basic_done");
    exp_frames++;
    tests++;
    if (wr_log.size() - wb != 20) begin
      fails++;
      $display("FAIL basic_writes: got %0d, required 20", wr_log.size() - wb);
    end
    errs = 0;
    for (int i = 0; i < 20 && wb + i < wr_log.size(); i++) begin
      exp = (i < 4) ? ONES_W : ((i < 16) ? mk_word(s0 + i - 4) : ZEROS_W);
      if (wr_log[wb + i] !== exp) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL basic_data: %0d wrong words, required 0", errs);
    end
    tests++;
    if (wr_cyc.size() <= wb || wr_cyc[wb] != st + 1) begin
      fails++;
      $display("FAIL basic_first_write: first write not at cycle %0d (start+1)", st + 1);
    end
    ok = 1'b0;
    if (sd_cyc.size() - sb == 3 && wr_cyc.size() - wb >= 16)
      ok = (sd_cyc[sb] == wr_cyc[wb + 7]) && (sd_cyc[sb + 1] == wr_cyc[wb + 11]) &&
           (sd_cyc[sb + 2] == wr_cyc[wb + 15]);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_subc_done: %0d pulses, required 3 aligned with writes 8/12/16",
               sd_cyc.size() - sb);
    end
    tests++;
    if (fd_cyc.size() - fb != 1 || fd_cyc[fb] != st + 20) begin
      fails++;
      $display("FAIL basic_frame_done: %0d pulses, required 1 at cycle %0d", fd_cyc.size() - fb, st + 20);
    end
    tests++;
    if (frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    int wb, fb, s0, vb, k, errs;
    logic [DATA_W-1:0] exp;
    wb = wr_log.size(); fb = fd_cyc.size(); s0 = src_idx; vb = full_viol;
    en_reset_masks = 1'b1; num_pat = 32'd2; num_streams = 16'd5;
    src_valid = 1'b1; out_full = 1'b0;
    pulse_start();
    k = 0;
    while (busy && k < 600) begin
      out_full  = ((k / 3) % 2) == 1;
      src_valid = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_full = 1'b0; src_valid = 1'b1;
    wait_idle(10, "bp_done");
    exp_frames++;
    tests++;
    if (full_viol != vb) begin
      fails++;
      $display("FAIL bp_write_after_full: %0d writes after full, required 0", full_viol - vb);
    end
    tests++;
    if (wr_log.size() - wb != 20 || src_idx - s0 != 10) begin
      fails++;
      $display("FAIL bp_counts: writes=%0d pops=%0d, required 20 10", wr_log.size() - wb, src_idx - s0);
    end
    errs = 0;
    for (int i = 0; i < 20 && wb + i < wr_log.size(); i++) begin
      exp = (i < 5) ? ONES_W : ((i < 15) ? mk_word(s0 + i - 5) : ZEROS_W);
      if (wr_log[wb + i] !== exp) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL bp_order: %0d wrong words, required 0", errs);
    end
    tests++;
    if (fd_cyc.size() - fb != 1 || frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL bp_frame: frame_cnt=%0d, required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_cfg_err();
    int cb, wb;
    logic bsy, seen;
    for (int t = 0; t < 2; t++) begin
      cb = cfg_cnt; wb = wr_log.size(); bsy = 1'b0;
      en_reset_masks = 1'b1;
      num_pat     = (t == 0) ? 32'd0 : 32'd3;
      num_streams = (t == 0) ? 16'd4 : 16'd0;
      pulse_start();
      seen = cfg_err;
      for (int k = 0; k < 4; k++) begin
        if (busy) bsy = 1'b1;
        tick();
      end
      tests++;
      if (seen !== 1'b1 || cfg_cnt - cb != 1) begin
        fails++;
        $display("FAIL cfg_err_%0d: pulse=%0b count=%0d, required 1 1", t, seen, cfg_cnt - cb);
      end
      tests++;
      if (bsy || wr_log.size() != wb) begin
        fails++;
        $display("FAIL cfg_idle_%0d: busy_seen=%0b writes=%0d, required 0 0", t, bsy, wr_log.size() - wb);
      end
    end
  endtask

  task automatic test_continuous();
    int wb, fb, s0, nfd, k, errs;
    wb = wr_log.size(); fb = fd_cyc.size(); s0 = src_idx;
    en_reset_masks = 1'b0; num_pat = 32'd2; num_streams = 16'd640;
    continuous = 1'b1; src_valid = 1'b1; out_full = 1'b0;
    pulse_start();
    nfd = 0; k = 0;
    while (nfd < 3 && k < 5000) begin
      if (frame_done) nfd++;
      if (nfd == 3) continuous = 1'b0;
      tick();
      k++;
    end
    continuous = 1'b0;
    wait_idle(10, "cont_done");
    exp_frames += 3;
    tests++;
    if (fd_cyc.size() - fb != 3) begin
      fails++;
      $display("FAIL cont_frames: got %0d frame_done, required 3", fd_cyc.size() - fb);
    end else begin
      tests++;
      if (fd_cyc[fb + 1] - fd_cyc[fb] != 1281 || fd_cyc[fb + 2] - fd_cyc[fb + 1] != 1281) begin
        fails++;
        $display("FAIL cont_period: got %0d %0d, required 1281 1281",
                 fd_cyc[fb + 1] - fd_cyc[fb], fd_cyc[fb + 2] - fd_cyc[fb + 1]);
      end
    end
    errs = 0;
    for (int i = 0; i < 3840 && wb + i < wr_log.size(); i++)
      if (wr_log[wb + i] !== mk_word(s0 + i)) errs++;
    tests++;
    if (wr_log.size() - wb != 3840 || errs != 0) begin
      fails++;
      $display("FAIL cont_data: writes=%0d bad=%0d, required 3840 0", wr_log.size() - wb, errs);
    end
    tests++;
    if (frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL cont_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_abort();
    int wb, fb, s0, k, errs;
    logic [DATA_W-1:0] exp;
    wb = wr_log.size(); fb = fd_cyc.size(); s0 = src_idx;
    en_reset_masks = 1'b1; num_pat = 32'd3; num_streams = 16'd200;
    src_valid = 1'b1; out_full = 1'b0;
    pulse_start();
    k = 0;
    while (src_idx - s0 < 300 && k < 2000) begin
      tick();
      k++;
    end
    abort = 1'b1;
    #1;
    tests++;
    if (src_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_rd_en: got %0b, required 0", src_rd_en);
    end
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%0b, required 0", busy);
    end
    tick(); tick(); tick();
    tests++;
    if (src_idx - s0 != 300 || wr_log.size() - wb != 500) begin
      fails++;
      $display("FAIL abort_counts: pops=%0d writes=%0d, required 300 500", src_idx - s0, wr_log.size() - wb);
    end else begin
      tests++;
      if (wr_log[wb + 499] !== mk_word(s0 + 299)) begin
        fails++;
        $display("FAIL abort_trailing: last write %0h, required %0h", wr_log[wb + 499], mk_word(s0 + 299));
      end
    end
    tests++;
    if (fd_cyc.size() != fb || frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL abort_no_frame: frame_cnt=%0d, required %0d", frame_cnt, exp_frames);
    end
    wb = wr_log.size(); s0 = src_idx;
    num_pat = 32'd2; num_streams = 16'd3;
    pulse_start();
    wait_idle(100, "abort_restart_done");
    exp_frames++;
    errs = 0;
    for (int i = 0; i < 12 && wb + i < wr_log.size(); i++) begin
      exp = (i < 3) ? ONES_W : ((i < 9) ? mk_word(s0 + i - 3) : ZEROS_W);
      if (wr_log[wb + i] !== exp) errs++;
    end
    tests++;
    if (wr_log.size() - wb != 12 || errs != 0 || frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL abort_restart: writes=%0d bad=%0d frame_cnt=%0d, required 12 0 %0d",
               wr_log.size() - wb, errs, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    int wb, k, s0;
    wb = wr_log.size();
    en_reset_masks = 1'b1; num_pat = 32'd2; num_streams = 16'd8;
    pulse_start();
    k = 0;
    while (wr_log.size() - wb < 27 && k < 200) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    exp_frames = 0;
    tests++;
    if ({out_wr, busy, subc_done, frame_done, cfg_err} !== 5'b0 || out_data !== ZEROS_W ||
        frame_cnt !== '0) begin
      fails++;
      $display("FAIL midrst_state: flags=%b frame_cnt=%0d, required 00000 0",
               {out_wr, busy, subc_done, frame_done, cfg_err}, frame_cnt);
    end
    rst = 1'b0;
    tick();
    wb = wr_log.size(); s0 = src_idx;
    en_reset_masks = 1'b0; num_pat = 32'd1; num_streams = 16'd2;
    pulse_start();
    wait_idle(50, "midrst_restart_done");
    exp_frames++;
    tests++;
    if (wr_log.size() - wb != 2 || frame_cnt !== CNT_W'(exp_frames)) begin
      fails++;
      $display("FAIL midrst_restart: writes=%0d frame_cnt=%0d, required 2 1", wr_log.size() - wb, frame_cnt);
    end else begin
      tests++;
      if (wr_log[wb] !== mk_word(s0) || wr_log[wb + 1] !== mk_word(s0 + 1)) begin
        fails++;
        $display("FAIL midrst_data: source words out of order after reset");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_continuous();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
